muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the 5-stage MIPS pipeline.
- Accepts a start pulse with an operation code from EX and models fixed MUL/DIV latency with a down-counter.
- Commits results to HI/LO at completion.
- Services direct HI/LO writes (mthi/mtlo).
- Generates the pipeline stall for ID-stage instructions touching HI/LO while an operation is in flight.

Parameters:
MUL_LAT, 5, busy cycles for mult/multu (legal range 1..31)
DIV_LAT, 10, busy cycles for div/divu (legal range 1..31)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  EX-stage mult/multu/div/divu present; one-cycle pulse
op  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
a  input  32  rs operand (multiplicand / dividend)
b  input  32  rt operand (multiplier / divisor)
hilo_we  input  1  EX-stage mthi/mtlo write enable
hilo_sel  input  1  1 = write HI, 0 = write LO
wdata  input  32  data for mthi/mtlo
uses_hilo_id  input  1  ID-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in flight
stall  output  1  freeze PC/IF/ID, bubble into EX
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, any time including mid-operation): state IDLE, counter 0, pending result discarded, hi=0, lo=0, busy=0. stall=0 only while uses_hilo_id=0 and start=0, since stall is combinational.
- States: IDLE, BUSY.
- IDLE, start=1 at edge t:
  - Compute the 64-bit result from a/b/op and hold it in internal result registers.
  - Load counter with MUL_LAT or DIV_LAT according to op[1].
  - Go to BUSY. busy=1 for cycles t+1 .. t+LAT.
- BUSY: counter decrements each edge. At the edge where counter==1:
  - Write result into HI/LO; go to IDLE.
  - busy=0 and new HI/LO visible from cycle t+LAT+1.
- Multiply results:
  - op 00: {hi,lo} = signed 32x32 -> 64 product.
  - op 01: {hi,lo} = unsigned 32x32 -> 64 product.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- Divide by zero (b==0, op 1x): full DIV_LAT busy period still runs; hi/lo unchanged at completion.
- IDLE, hilo_we=1 and start=0: the selected register takes wdata at the edge; visible next cycle.
- IDLE, start=1 and hilo_we=1 in the same cycle: start wins; hilo_we ignored.
- BUSY, start=1 or hilo_we=1 (protocol violation, prevented by stall): ignored; no effect on counter, HI or LO.
- stall = uses_hilo_id & (start | busy), combinational. It covers the back-to-back case where the ID instr follows a start in EX.
- hi/lo outputs are driven directly from registers; no bypass of pending results.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0, stall=0; assert rst mid-BUSY -> busy and hi/lo go to 0 immediately, and no commit occurs after rst releases.
- start op=00, a=0xFFFFFFFD (-3), b=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; same with op=01 -> hi=0x00000006, lo=0xFFFFFFEB.
- start op=11, a=100, b=7 -> busy exactly 10 cycles, then lo=14, hi=2; op=10, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via hilo_we, then op=10 with b=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- start op=00 with uses_hilo_id=1 (mflo) held -> stall=1 in the start cycle and all 5 busy cycles, stall=0 in the cycle after completion while lo already shows the product.
- Same-cycle start=1 and hilo_we=1 in IDLE -> wdata discarded, product committed; hilo_we=1 during BUSY -> ignored, final hi/lo equal the operation result.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Result is computed at start, held for a fixed latency, then committed.
module muldiv_seq #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  input  logic        uses_hilo_id,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = 5;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             commit_q, commit_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] smul_c, umul_c, result_c;
  logic [31:0] a_mag_c, b_mag_c, num_c, den_c, uq_c, ur_c, q_c, r_c;
  logic        div_zero_c;

  // Datapath: products and sign-magnitude division with truncation toward zero
  always_comb begin
    smul_c     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    umul_c     = {32'd0, a} * {32'd0, b};
    a_mag_c    = a[31] ? (~a + 32'd1) : a;
    b_mag_c    = b[31] ? (~b + 32'd1) : b;
    num_c      = op[0] ? a : a_mag_c;
    den_c      = op[0] ? b : b_mag_c;
    div_zero_c = (b == 32'd0);
    if (div_zero_c) den_c = 32'd1;
    uq_c = num_c / den_c;
    ur_c = num_c % den_c;
    q_c  = (!op[0] && (a[31] ^ b[31])) ? (~uq_c + 32'd1) : uq_c;
    r_c  = (!op[0] && a[31]) ? (~ur_c + 32'd1) : ur_c;
    case (op)
      2'b00:   result_c = smul_c;
      2'b01:   result_c = umul_c;
      default: result_c = {r_c, q_c};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state: launch on start, count down, commit on the final busy cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          res_d    = result_c;
          commit_d = !(op[1] && div_zero_c);
          cnt_d    = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_d  = ST_BUSY;
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = wdata;
          else          lo_d = wdata;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (commit_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = uses_hilo_id & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic HI/LO model.
module tb_muldiv_seq;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hilo_we, hilo_sel;
  logic [31:0] wdata;
  logic        uses_hilo_id;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
    .uses_hilo_id(uses_hilo_id), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result as {hi,lo} using wide integer arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: return {32'(ux % uy), 32'(ux / uy)};
    endcase
  endfunction

  task automatic write_hilo(input logic sel, input logic [31:0] d);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = sel; wdata = d;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) m_hi = d; else m_lo = d;
    check(sel ? "mthi" : "mtlo", {hi, lo}, {m_hi, m_lo});
  endtask

  // Run one operation; optionally hold ID hazard, collide with mthi, or inject illegal requests mid-busy
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic uid, input logic we_same, input logic inject);
    int cnt;
    int lat;
    logic [63:0] r;
    lat = o[1] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; uses_hilo_id = uid;
    hilo_we = we_same; hilo_sel = 1'b1; wdata = 32'hDEAD_BEEF;
    #1 check("stall_start", 64'(stall), 64'(uid));
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    a = $urandom; b = $urandom;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      check("stall_busy", 64'(stall), 64'(uid));
      if (inject && cnt == 2) begin
        start = 1'b1; op = 2'(($urandom)); hilo_we = 1'b1; hilo_sel = 1'($urandom); wdata = $urandom;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hilo_we = 1'b0;
    check("busy_len", 64'(cnt), 64'(lat));
    if (!(o[1] && y == 32'd0)) begin
      r = ref_res(o, x, y);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    check("hilo", {hi, lo}, {m_hi, m_lo});
    check("stall_done", 64'(stall), 64'd0);
    uses_hilo_id = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; wdata = '0; uses_hilo_id = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
    check("mul_s_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
    check("mul_u_dir", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    check("div_u_dir", {hi, lo}, {32'd2, 32'd14});
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    check("div_s_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    write_hilo(1'b1, 32'h11);
    write_hilo(1'b0, 32'h22);
    do_op(2'b10, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
    check("div_zero", {hi, lo}, {32'h11, 32'h22});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op(2'b00, 32'd12345, 32'd678, 1'b1, 1'b0, 1'b0);
    do_op(2'b00, 32'd3, 32'd9, 1'b0, 1'b1, 1'b0);
    check("start_wins", {hi, lo}, {32'd0, 32'd27});
    do_op(2'b11, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b1);
    check("busy_ignore", {hi, lo}, {32'd1, 32'd333});

    // Asynchronous reset in the middle of a divide
    write_hilo(1'b1, 32'hAAAA_5555);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (DIV_LAT + 3) @(negedge clk);
    check("no_commit_after_rst", {hi, lo}, 64'd0);
    check("no_busy_after_rst", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic [1:0] o;
      x = $urandom;
      y = $urandom;
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(0, 9));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) write_hilo(1'($urandom), $urandom);
      do_op(o, x, y, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
